serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Sequencer that shares one 4-bit ripple_adder slice across a wide addition. Each cycle it feeds one nibble of A and B into the slice and holds the slice carry in a register between cycles. The 4*NSLICES-bit SUM is built over NSLICES cycles. Valid/ready handshakes on both the operand side and the result side let it drop into any datapath stage that trades area for latency.

Parameters:
NSLICES, 4, number of 4-bit slices per operand; operand width W = 4*NSLICES; legal range 2..16
IDXW, 4, width of nibble index counter; must satisfy 2**IDXW >= NSLICES

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands A, B, ci present
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  W  addend
B  input  W  addend
ci  input  1  carry-in for bit 0
out_valid  output  1  SUM/co valid, held until accepted
out_ready  input  1  consumer accepts result
SUM  output  W  registered sum
co  output  1  registered carry out of bit W-1
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: on a clk edge with rst=1, go to IDLE. Outputs: in_ready=1, out_valid=0, busy=0, SUM=0, co=0. Internal: idx=0, carry reg=0, operand regs=0. rst overrides every other input, including mid-RUN and DONE; any in-flight result is discarded.
- States: IDLE, RUN, DONE (binary encoded).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture A->a_r, B->b_r, ci->carry, idx=0; go to RUN.
  - Otherwise hold.
- RUN:
  - in_ready=0.
  - Each cycle, slice inputs are a_r[4*idx+3:4*idx], b_r[4*idx+3:4*idx], carry.
  - At the edge: SUM[4*idx+3:4*idx] <= slice sum; carry <= slice co; idx <= idx+1.
  - On the edge where idx==NSLICES-1: co <= slice co; go to DONE.
- DONE:
  - out_valid=1; SUM and co stable.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE. There is no same-cycle turnaround, so the next operand is accepted at the earliest one cycle after the result handshake.
- Latency: acceptance at edge T; nibbles written at edges T+1..T+NSLICES; out_valid=1 in the cycle after edge T+NSLICES. Throughput is one add per NSLICES+2 cycles without backpressure.
- SUM during RUN is partial and undefined for the consumer. It holds its last value in IDLE until the next result overwrites it.
- in_valid in RUN or DONE is ignored and not queued. The A/B/ci pins may change freely after acceptance.
- Arithmetic: {co,SUM} = A + B + ci, modulo 2**(W+1), unsigned. No saturation.
- idx never exceeds NSLICES-1. No wrap-around is required within one operation.
- Slice: exactly one ripple_adder instance, ports (co, SUM, A, B, ci), default n=4. No other adder logic.

Optional Feature:
Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - On the last RUN edge, ovf <= (a_r[W-1]==b_r[W-1]) & (slice sum bit 3 != a_r[W-1]). This is the two's-complement signed overflow.
  - ovf is valid together with out_valid and held in DONE.
- Undefined: no ovf port and no related logic; behaviour is otherwise identical.

Test Plan:
1. NSLICES=4, A=0x1234, B=0x4321, ci=0 -> out_valid 4 cycles after the acceptance edge; SUM=0x5555, co=0, ovf=0.
2. A=0xFFFF, B=0x0001, ci=0 -> carry ripples through all four nibbles; SUM=0x0000, co=1. Also A=0xFFFF, B=0x0000, ci=1 -> SUM=0x0000, co=1.
3. Backpressure: result SUM=0x5555 with out_ready=0 for 5 cycles -> out_valid, SUM and co stable, in_ready=0. Then out_ready=1 for 1 cycle -> IDLE next cycle, in_ready=1.
4. in_valid pulses with A=0xAAAA during RUN and DONE -> ignored; the in-flight result is still 0x5555. A new op accepted after return to IDLE gives the correct sum.
5. Assert rst for 1 cycle during RUN (idx=2) -> the next cycle shows IDLE, in_ready=1, out_valid=0, SUM=0, co=0. A following add 0x0F0F+0x0101 gives 0x1010, co=0.
6. With SERIAL_ADD_OVF_EN: 0x7FFF+0x0001 -> SUM=0x8000, ovf=1, co=0. 0x8000+0x8000 -> SUM=0x0000, co=1, ovf=1. 0x1234+0x4321 -> ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: wide unsigned adder built from one shared 4-bit ripple
// slice. Each RUN cycle adds one nibble of the captured operands, and the slice
// carry is kept in a register between cycles.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf.

// n-bit ripple-carry adder used as the shared slice
module ripple_adder #(
    parameter int n = 4
) (
    output logic         co,
    output logic [n-1:0] SUM,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         ci
);

    // Bit-serial carry chain, LSB first
    always_comb begin : chain
        logic c;
        c   = ci;
        SUM = '0;
        for (int unsigned i = 0; i < n; i++) begin
            SUM[i] = A[i] ^ B[i] ^ c;
            c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        co = c;
    end

endmodule

module serial_add_ctrl #(
    parameter int NSLICES = 4,
    parameter int IDXW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NSLICES-1:0] A,
    input  logic [4*NSLICES-1:0] B,
    input  logic                 ci,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NSLICES-1:0] SUM,
    output logic                 co,
    output logic                 busy
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int W = 4 * NSLICES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic       slice_co;
    logic       last;

    assign last = (idx == IDXW'(NSLICES - 1));

    // The single shared adder slice
    ripple_adder #(.n(4)) u_slice (
        .co  (slice_co),
        .SUM (slice_sum),
        .A   (slice_a),
        .B   (slice_b),
        .ci  (carry)
    );

    // Select the current nibble of each captured operand
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NSLICES; i++) begin
            if (idx == IDXW'(i)) begin
                slice_a = a_r[4*i +: 4];
                slice_b = b_r[4*i +: 4];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) state_nx = S_RUN;
            S_RUN:  if (last)     state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: in_ready  = 1'b1;
            S_RUN:  busy      = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand capture, per-nibble accumulation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            SUM   <= '0;
            co    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r   <= A;
                        b_r   <= B;
                        carry <= ci;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    for (int unsigned i = 0; i < NSLICES; i++) begin
                        if (idx == IDXW'(i)) begin
                            SUM[4*i +: 4] <= slice_sum;
                        end
                    end
                    carry <= slice_co;
                    if (last) begin
                        co <= slice_co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf <= (a_r[W-1] == b_r[W-1]) & (slice_sum[3] != a_r[W-1]);
`endif
                    end else begin
                        // idx stops at the last slice rather than wrapping
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed vectors with literal expectations plus a
// cycle-count model compared against the DUT on every negative clock edge.
module tb_serial_add_ctrl;

    localparam int NS = 4;
    localparam int W  = 4 * NS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] SUM;
    logic         co;
    logic         busy;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.NSLICES(NS), .IDXW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .co        (co),
        .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op keeps the block busy for NS cycles, then
    // the sum A+B+ci is presented until out_ready is seen.
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic         m_live = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_co   = 1'b0;
    logic [W-1:0] p_sum  = '0;
    logic         p_co   = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    logic         m_ovf  = 1'b0;
    logic         p_ovf  = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_live <= 1'b1;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_co   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            m_ovf  <= 1'b0;
`endif
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_sum  <= p_sum;
                m_co   <= p_co;
`ifdef SERIAL_ADD_OVF_EN
                m_ovf  <= p_ovf;
`endif
            end
        end else if (in_valid) begin
            m_cnt <= NS;
            {p_co, p_sum} <= {1'b0, A} + {1'b0, B} + (W+1)'(ci);
`ifdef SERIAL_ADD_OVF_EN
            p_ovf <= (A[W-1] == B[W-1]) &&
                     (((A + B + W'(ci)) >> (W - 1)) != W'(A[W-1]));
`endif
        end
    end

    // Compare process: status every cycle, result whenever it is defined
    always @(negedge clk) begin
        if (m_live) begin
            check("m_in_ready",  32'(in_ready),  32'(!(m_cnt > 0 || m_done)));
            check("m_out_valid", 32'(out_valid), 32'(m_done));
            check("m_busy",      32'(busy),      32'(m_cnt > 0 || m_done));
            if (m_cnt == 0) begin
                check("m_sum", 32'(SUM), 32'(m_sum));
                check("m_co",  32'(co),  32'(m_co));
`ifdef SERIAL_ADD_OVF_EN
                check("m_ovf", 32'(ovf), 32'(m_ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) check("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_in_ready",  32'(in_ready),  32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic eco, input logic eovf,
                         input int hold);
        int n;
        A = a; B = b; ci = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); ci = 1'($urandom);
        wait_valid(n);
        check("latency", 32'(n), 32'(NS));
        check("sum",     32'(SUM), 32'(es));
        check("co",      32'(co),  32'(eco));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf",     32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) check("ovf_arg", 32'(eovf), 32'd0);
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid",    32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready),  32'd0);
            check("hold_sum",      32'(SUM),       32'(es));
            check("hold_co",       32'(co),        32'(eco));
        end
        handshake();
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ci = 1'b0;
        tick(); tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_sum",       32'(SUM),       32'd0);
        check("rst_co",        32'(co),        32'd0);
        rst = 1'b0;
        tick();

        // Basic add and full-width carry ripple
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);

        // Backpressure: result held for 5 cycles
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5);

        // in_valid during RUN and DONE is ignored
        A = 16'h1234; B = 16'h4321; ci = 1'b0; in_valid = 1'b1;
        tick();
        A = 16'hAAAA; B = 16'hAAAA;
        wait_valid(n);
        check("ign_latency", 32'(n), 32'(NS));
        tick(); tick();
        in_valid = 1'b0;
        check("ign_sum",   32'(SUM),       32'h5555);
        check("ign_valid", 32'(out_valid), 32'd1);
        handshake();
        do_op(16'hAAAA, 16'h1111, 1'b0, 16'hBBBB, 1'b0, 1'b0, 0);

        // Reset in the middle of RUN (idx == 2)
        A = 16'h1234; B = 16'h4321; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",       32'(SUM),       32'd0);
        check("mid_rst_co",        32'(co),        32'd0);
        do_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 0);

        // Signed-overflow vectors
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
        do_op(16'h8001, 16'h7FFF, 1'b1, 16'h0001, 1'b1, 1'b0, 0);

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
